// File: rtl/attn_pkg.sv
// Shared sizing constants and FSM encoding for the attention token loader.
package attn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int TOKEN_DIM  = 4;
  localparam int TOKEN_NUM  = 8;
  localparam int TOKEN_W    = DATA_WIDTH * TOKEN_DIM;
  localparam int MAT_W      = TOKEN_W * TOKEN_NUM;
  localparam int CNT_W      = $clog2(TOKEN_NUM);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/attn_mat_buffer.sv
// TOKEN_NUM x TOKEN_W register bank: one row written per enable, whole bank
// cleared synchronously or by async reset. Row 0 lands at the LSBs of o_mat.
module attn_mat_buffer #(
  parameter int TOKEN_W   = 64,
  parameter int TOKEN_NUM = 8,
  parameter int CNT_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic                         i_clr,
  input  logic [CNT_W-1:0]             i_slot,
  input  logic [TOKEN_W-1:0]           i_data,
  output logic [TOKEN_W*TOKEN_NUM-1:0] o_mat
);
  logic [TOKEN_W-1:0] r_mem [TOKEN_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TOKEN_NUM; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < TOKEN_NUM; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_slot] <= i_data;
    end
  end

  for (genvar g = 0; g < TOKEN_NUM; g++) begin : g_flat
    assign o_mat[g*TOKEN_W +: TOKEN_W] = r_mem[g];
  end
endmodule

// File: rtl/attn_token_loader.sv
// Collects one Q/K/V token row per beat into full matrices and hands each
// completed frame downstream; framing errors are flagged and zero-padded.
module attn_token_loader
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_last,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]           in_q,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]           in_k,
  input  logic [DATA_WIDTH*TOKEN_DIM-1:0]           in_v,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V,
  output logic                                   frame_err,
  output state_t                                 o_state
);
  localparam int L_TOKEN_W = DATA_WIDTH * TOKEN_DIM;
  localparam int L_CNT_W   = $clog2(TOKEN_NUM);

  state_t               r_state;
  logic [L_CNT_W-1:0]   r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_frame_err;

  logic w_accept, w_slot_last, w_close, w_err, w_clr;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready and out_valid are registered and depend only on state, never
  // combinationally on in_valid/out_ready.
  assign w_accept    = in_valid && r_in_ready;
  assign w_slot_last = (r_cnt == L_CNT_W'(TOKEN_NUM - 1));
  assign w_close     = w_accept && (w_slot_last || in_last);
  // Early last or missing last both mean in_last disagrees with the slot.
  assign w_err       = w_accept && (w_slot_last != in_last);
  assign w_clr       = (r_state == FULL) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_close) begin
            r_state     <= FULL;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_frame_err <= w_err;
          end else if (w_accept) begin
            r_cnt <= r_cnt + L_CNT_W'(1);
          end
        end
        FULL: begin
          if (out_ready) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign o_state   = r_state;

  attn_mat_buffer #(.TOKEN_W(L_TOKEN_W), .TOKEN_NUM(TOKEN_NUM), .CNT_W(L_CNT_W)) u_q_buf (
    .clk(clk), .rst(rst), .i_we(w_accept), .i_clr(w_clr), .i_slot(r_cnt), .i_data(in_q), .o_mat(Q)
  );
  attn_mat_buffer #(.TOKEN_W(L_TOKEN_W), .TOKEN_NUM(TOKEN_NUM), .CNT_W(L_CNT_W)) u_k_buf (
    .clk(clk), .rst(rst), .i_we(w_accept), .i_clr(w_clr), .i_slot(r_cnt), .i_data(in_k), .o_mat(K)
  );
  attn_mat_buffer #(.TOKEN_W(L_TOKEN_W), .TOKEN_NUM(TOKEN_NUM), .CNT_W(L_CNT_W)) u_v_buf (
    .clk(clk), .rst(rst), .i_we(w_accept), .i_clr(w_clr), .i_slot(r_cnt), .i_data(in_v), .o_mat(V)
  );
endmodule

// File: tb/tb_attn_token_loader.sv
// Directed bench for attn_token_loader: table of frames plus hand-written
// backpressure, mid-frame reset and back-to-back sequences.
module tb_attn_token_loader;
  import attn_pkg::*;

  localparam int TW = TOKEN_W;
  localparam int MW = MAT_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [TW-1:0] in_q = '0, in_k = '0, in_v = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MW-1:0] Q, K, V;
  logic          frame_err;
  state_t        o_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [MW-1:0] exp_q[$];

  typedef struct {
    int          n_beats;
    int          last_at;   // -1: in_last never asserted
    logic [15:0] base;
    logic        exp_err;
  } vec_t;

  attn_token_loader #(.DATA_WIDTH(DATA_WIDTH), .TOKEN_DIM(TOKEN_DIM), .TOKEN_NUM(TOKEN_NUM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_q(in_q), .in_k(in_k), .in_v(in_v), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .K(K), .V(V), .frame_err(frame_err), .o_state(o_state)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- helpers
  function automatic logic [TW-1:0] rep(input logic [15:0] e);
    logic [TW-1:0] r;
    for (int j = 0; j < TOKEN_DIM; j++) r[j*16 +: 16] = e;
    return r;
  endfunction

  function automatic logic [MW-1:0] exp_mat(input logic [15:0] base, input int n, input int off);
    logic [MW-1:0] m;
    logic [15:0]   e;
    m = '0;
    for (int i = 0; i < TOKEN_NUM; i++) begin
      if (i < n) begin
        e = base * 16'(i + 1) + 16'(off);
        m[i*TW +: TW] = rep(e);
      end
    end
    return m;
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks
  task automatic drive_beat(input logic [15:0] e, input logic last);
    in_valid = 1'b1;
    in_q     = rep(e);
    in_k     = rep(e + 16'd1);
    in_v     = rep(e + 16'd2);
    in_last  = last;
  endtask

  // Drives n beats from FILL; returns at the negedge after the final beat.
  task automatic send_frame(input int n, input int last_at, input logic [15:0] base);
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) chk("ov_low_while_filling", MW'(out_valid), MW'(0));
      e = base * 16'(i + 1);
      drive_beat(e, i == last_at);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [15:0] base, input int n, input logic err);
    chk({nm, "_ov"}, MW'(out_valid), MW'(1));
    chk({nm, "_ir"}, MW'(in_ready), MW'(0));
    chk({nm, "_err"}, MW'(frame_err), MW'(err));
    chk({nm, "_Q"}, Q, exp_mat(base, n, 0));
    chk({nm, "_K"}, K, exp_mat(base, n, 1));
    chk({nm, "_V"}, V, exp_mat(base, n, 2));
  endtask

  task automatic check_turnaround(input string nm);
    @(negedge clk);
    chk({nm, "_ov_drop"}, MW'(out_valid), MW'(0));
    chk({nm, "_err_drop"}, MW'(frame_err), MW'(0));
    chk({nm, "_ir_back"}, MW'(in_ready), MW'(1));
    chk({nm, "_Q_cleared"}, Q, '0);
  endtask

  // ---------------- stimulus
  initial begin
    vec_t vecs[5];
    logic [MW-1:0] held_exp;
    int  idx, frames, last_ov;
    logic w_rdy;
    logic [15:0] fbase;

    vecs[0] = '{n_beats: 8, last_at:  7, base: 16'h0100, exp_err: 1'b0};
    vecs[1] = '{n_beats: 3, last_at:  2, base: 16'h0001, exp_err: 1'b1};
    vecs[2] = '{n_beats: 8, last_at: -1, base: 16'h0010, exp_err: 1'b1};
    vecs[3] = '{n_beats: 1, last_at:  0, base: 16'h0020, exp_err: 1'b1};
    vecs[4] = '{n_beats: 8, last_at:  7, base: 16'h1111, exp_err: 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ov", MW'(out_valid), MW'(0));
    chk("rst_err", MW'(frame_err), MW'(0));
    chk("rst_ir", MW'(in_ready), MW'(1));
    chk("rst_state", MW'(o_state), MW'(FILL));
    chk("rst_Q", Q, '0);
    chk("rst_K", K, '0);
    chk("rst_V", V, '0);

    // table-driven frames, out_ready tied high
    for (int t = 0; t < 5; t++) begin
      send_frame(vecs[t].n_beats, vecs[t].last_at, vecs[t].base);
      check_frame($sformatf("vec%0d", t), vecs[t].base, vecs[t].n_beats, vecs[t].exp_err);
      check_turnaround($sformatf("vec%0d", t));
    end

    // backpressure: frame held for 5 cycles, offered beat must wait
    out_ready = 1'b0;
    send_frame(8, 7, 16'h0200);
    check_frame("bp", 16'h0200, 8, 1'b0);
    held_exp = exp_mat(16'h0200, 8, 0);
    drive_beat(16'h0ABC, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_ov_hold", MW'(out_valid), MW'(1));
      chk("bp_ir_hold", MW'(in_ready), MW'(0));
      chk("bp_Q_stable", Q, held_exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ir", MW'(in_ready), MW'(1));
    chk("bp_release_ov", MW'(out_valid), MW'(0));
    chk("bp_release_Q", Q, '0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_held_ov", MW'(out_valid), MW'(1));
    chk("bp_held_err", MW'(frame_err), MW'(1));
    chk("bp_held_Q", Q, MW'(rep(16'h0ABC)));
    chk("bp_held_V", V, MW'(rep(16'h0ABE)));
    check_turnaround("bp");

    // reset mid-frame after 4 beats
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_beat(16'h0A00 * 16'(i + 1), 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_partial_Q", Q, exp_mat(16'h0A00, 4, 0));
    rst = 1'b1;
    #1;
    chk("mid_rst_Q", Q, '0);
    chk("mid_rst_K", K, '0);
    chk("mid_rst_V", V, '0);
    chk("mid_rst_ov", MW'(out_valid), MW'(0));
    chk("mid_rst_state", MW'(o_state), MW'(FILL));
    @(negedge clk);
    rst = 1'b0;
    send_frame(8, 7, 16'h0500);
    check_frame("mid_clean", 16'h0500, 8, 1'b0);
    check_turnaround("mid_clean");

    // back-to-back frames, in_valid held high
    exp_q.push_back(exp_mat(16'h0300, 8, 0));
    exp_q.push_back(exp_mat(16'h0400, 8, 0));
    idx = 0; frames = 0; last_ov = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b_extra_frame", MW'(1), MW'(0));
        end else begin
          chk("b2b_Q", Q, exp_q.pop_front());
        end
        if (last_ov >= 0) chk("b2b_period", MW'(c - last_ov), MW'(9));
        last_ov = c;
        frames++;
      end
      if (frames == 2 && idx == 16) break;
      if (idx < 16) begin
        fbase = (idx < 8) ? 16'h0300 : 16'h0400;
        drive_beat(fbase * 16'((idx % 8) + 1), (idx % 8) == 7);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      w_rdy = in_ready;
      @(posedge clk);
      if (in_valid && w_rdy) idx++;
    end
    in_valid = 1'b0;
    chk("b2b_frames_seen", MW'(frames), MW'(2));
    chk("b2b_beats_taken", MW'(idx), MW'(16));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/attn_token_loader.md
Name: attn_token_loader

Overview:
- Front-end stage that feeds the attention pipeline's Q/K/V inputs.
- Accepts one token row per beat, carrying Q, K and V for the same token index, over a valid/ready stream.
- Assembles full TOKEN_NUM x TOKEN_DIM matrices in internal buffers.
- Presents the completed matrices as wide buses with an out_valid/out_ready handshake.
- Framing errors are flagged and padded rather than stalling the pipeline.

Parameters:
- DATA_WIDTH, 16, element width (Q8.8 fixed point, passed through untouched)
- TOKEN_DIM, 4, elements per token
- TOKEN_NUM, 8, tokens per frame (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  loader can accept a beat
- in_last  in  1  marks final token of frame
- in_q  in  DATA_WIDTH*TOKEN_DIM  Q row of current token
- in_k  in  DATA_WIDTH*TOKEN_DIM  K row of current token
- in_v  in  DATA_WIDTH*TOKEN_DIM  V row of current token
- out_valid  out  1  Q/K/V hold a complete frame
- out_ready  in  1  consumer takes frame (tie high for the free-running pipeline)
- Q  out  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  assembled Q matrix
- K  out  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  assembled K matrix
- V  out  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  assembled V matrix
- frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (async assert, sync-release use):
  - state=FILL, slot counter cnt=0.
  - All Q/K/V buffer bits 0; out_valid=0, frame_err=0.
  - in_ready=1 once rst is low.
- Layout: token i occupies bits [i*DATA_WIDTH*TOKEN_DIM +: DATA_WIDTH*TOKEN_DIM]; token 0 is at the LSBs. Element order inside a row is unchanged from the input.
- Beat acceptance: a beat is accepted when in_valid && in_ready at the rising edge.
- State FILL:
  - in_ready=1, out_valid=0.
  - An accepted beat writes in_q/in_k/in_v into slot cnt of the respective buffers.
  - If cnt==TOKEN_NUM-1, or in_last=1: go to FULL and clear cnt. Otherwise cnt+=1.
- State FULL:
  - in_ready=0, out_valid=1.
  - Q/K/V remain stable while out_valid=1 and !out_ready.
  - On out_ready=1: go to FILL, cnt=0, and zero all buffers in the same edge.
- Throughput: at least TOKEN_NUM+1 cycles per frame (one bubble on the FULL->FILL turnaround). With out_ready tied high, out_valid is a one-cycle pulse. The downstream input register samples Q/K/V on that cycle.
- Latency: the frame is visible on Q/K/V and out_valid the cycle after the final beat is accepted.
- Early in_last (accepted with cnt<TOKEN_NUM-1):
  - Frame closes; unfilled slots stay 0 from the clear.
  - frame_err pulses high for exactly one cycle, the cycle out_valid first rises.
- Missing in_last (beat at cnt==TOKEN_NUM-1 with in_last=0):
  - Frame closes normally.
  - frame_err pulses as above.
  - No beats are dropped or merged across frames.
- in_valid while in FULL: beat is not accepted; upstream must hold it (standard valid/ready, no combinational in_valid->in_ready path).
- out_ready while in FILL: ignored.
- Reset mid-frame: partial frame discarded, all state returns to reset values immediately.
- No arithmetic on data; widths are exact concatenations, with no sign extension or saturation.

Decomposition:
- Package attn_pkg holds:
  - TOKEN_W = DATA_WIDTH*TOKEN_DIM
  - MAT_W = TOKEN_W*TOKEN_NUM
  - CNT_W = $clog2(TOKEN_NUM)
  - state encoding {FILL, FULL}
- Sub-module attn_mat_buffer (instantiated 3x for Q/K/V):
  - TOKEN_NUM x TOKEN_W register bank with write-enable, slot index and synchronous clear, plus async reset to 0.
  - The loader top holds the FSM, counter and error logic.

Test Plan:
- Full frame: 8 beats, token i has all elements 16'h0100*(i+1) in Q, +1 in K, +2 in V, in_last on beat 7, out_ready=1. Required: out_valid is high for 1 cycle the cycle after beat 7; Q slot i = 16'h0100*(i+1) in every element; frame_err=0.
- Backpressure: out_ready=0 for 5 cycles after the frame completes. Required: out_valid and Q/K/V stable for all 5 cycles; in_ready=0 and an offered beat is not consumed. Release out_ready: FILL resumes, in_ready=1 the next cycle, and the held beat lands in slot 0.
- Early last: 3 beats (values 1,2,3), in_last on beat 2. Required: slots 0-2 = 1,2,3; slots 3-7 = 0; frame_err pulses once, aligned with out_valid.
- Missing last: 8 beats, in_last=0 throughout. Required: frame completes after beat 7, frame_err pulses once, and the next beat goes to slot 0 of a new frame.
- Reset mid-frame: rst asserted after 4 beats, then a clean 8-beat frame. Required: outputs are 0 immediately on rst; the new frame contains no residue from the aborted beats.
- Back-to-back frames with in_valid held high: each frame occupies 9 cycles, with beat order preserved and no beat lost.
